// File: rtl/e203_flush_pkg.sv
// e203_flush_pkg: shared types and default widths for the EXU flush arbiter.
// Provides the flush source encoding, arbiter state encoding and widths.
package e203_flush_pkg;

    localparam int FLUSH_PC_W  = 32;
    localparam int FLUSH_CNT_W = 16;

    typedef enum logic {
        FLUSH_SRC_BRCH = 1'b0,
        FLUSH_SRC_EXCP = 1'b1
    } flush_src_e;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } flush_arb_st_e;

endpackage

// File: rtl/e203_flush_sat_cnt.sv
// e203_flush_sat_cnt: saturating event counter, one per flush source.
// Ports: clk, clr (sync clear), inc (count one event), cnt (current count).
module e203_flush_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/e203_exu_flush_arb.sv
// e203_exu_flush_arb: arbitrates the IFU flush port between exception and
// branch requesters (exception wins), holds the winner's target operands
// until the IFU acks, and counts completed flushes per source.
// Ports: clk/rst (sync, active-high); excp_* and brch_* request/operand
// inputs with one-cycle acks; pipe_flush_* request/operands/src to the IFU
// with pipe_flush_ack back; flush_busy stalls commit; *_flush_cnt counters.
module e203_exu_flush_arb
    import e203_flush_pkg::*;
#(
    parameter int PC_W  = FLUSH_PC_W,
    parameter int CNT_W = FLUSH_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             excp_flush_req,
    input  logic [PC_W-1:0]  excp_flush_add_op1,
    input  logic [PC_W-1:0]  excp_flush_add_op2,
    input  logic             brch_flush_req,
    input  logic [PC_W-1:0]  brch_flush_add_op1,
    input  logic [PC_W-1:0]  brch_flush_add_op2,
    output logic             excp_flush_ack,
    output logic             brch_flush_ack,
    output logic             pipe_flush_req,
    output logic [PC_W-1:0]  pipe_flush_add_op1,
    output logic [PC_W-1:0]  pipe_flush_add_op2,
    output logic             pipe_flush_src,
    input  logic             pipe_flush_ack,
    output logic             flush_busy,
    output logic [CNT_W-1:0] excp_flush_cnt,
    output logic [CNT_W-1:0] brch_flush_cnt
);

    flush_arb_st_e   state_q;
    flush_src_e      src_q;
    logic [PC_W-1:0] op1_q;
    logic [PC_W-1:0] op2_q;
    logic            hold;
    logic            ack_fire;

    assign hold     = (state_q == ARB_HOLD);
    assign ack_fire = hold & pipe_flush_ack;

    // Capture only in IDLE; while holding, requester inputs are
    // deliberately ignored so the IFU sees a stable request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            src_q   <= FLUSH_SRC_BRCH;
            op1_q   <= '0;
            op2_q   <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (excp_flush_req) begin
                        state_q <= ARB_HOLD;
                        src_q   <= FLUSH_SRC_EXCP;
                        op1_q   <= excp_flush_add_op1;
                        op2_q   <= excp_flush_add_op2;
                    end else if (brch_flush_req) begin
                        state_q <= ARB_HOLD;
                        src_q   <= FLUSH_SRC_BRCH;
                        op1_q   <= brch_flush_add_op1;
                        op2_q   <= brch_flush_add_op2;
                    end
                end
                ARB_HOLD: begin
                    if (pipe_flush_ack) begin
                        state_q <= ARB_IDLE;
                    end
                end
            endcase
        end
    end

    assign pipe_flush_req     = hold;
    assign flush_busy         = hold;
    assign pipe_flush_add_op1 = op1_q;
    assign pipe_flush_add_op2 = op2_q;
    assign pipe_flush_src     = src_q;

    assign excp_flush_ack = ack_fire & (src_q == FLUSH_SRC_EXCP);
    assign brch_flush_ack = ack_fire & (src_q == FLUSH_SRC_BRCH);

    e203_flush_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_excp_cnt (
        .clk (clk),
        .clr (rst),
        .inc (excp_flush_ack),
        .cnt (excp_flush_cnt)
    );

    e203_flush_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_brch_cnt (
        .clk (clk),
        .clr (rst),
        .inc (brch_flush_ack),
        .cnt (brch_flush_cnt)
    );

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// tb_e203_exu_flush_arb: table-driven bench for the flush arbiter plus a
// hand-written saturation sequence on a CNT_W=2 instance.
module tb_e203_exu_flush_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        er;
    logic [31:0] eo1, eo2;
    logic        br;
    logic [31:0] bo1, bo2;
    logic        pa;

    logic        ea, ba, pr, ps, busy;
    logic [31:0] po1, po2;
    logic [15:0] ec, bc;

    logic        ea_s, ba_s, pr_s, ps_s, busy_s;
    logic [31:0] po1_s, po2_s;
    logic [1:0]  ec_s, bc_s;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    e203_exu_flush_arb #(.PC_W(32), .CNT_W(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .excp_flush_req     (er),
        .excp_flush_add_op1 (eo1),
        .excp_flush_add_op2 (eo2),
        .brch_flush_req     (br),
        .brch_flush_add_op1 (bo1),
        .brch_flush_add_op2 (bo2),
        .excp_flush_ack     (ea),
        .brch_flush_ack     (ba),
        .pipe_flush_req     (pr),
        .pipe_flush_add_op1 (po1),
        .pipe_flush_add_op2 (po2),
        .pipe_flush_src     (ps),
        .pipe_flush_ack     (pa),
        .flush_busy         (busy),
        .excp_flush_cnt     (ec),
        .brch_flush_cnt     (bc)
    );

    e203_exu_flush_arb #(.PC_W(32), .CNT_W(2)) dut_s (
        .clk                (clk),
        .rst                (rst),
        .excp_flush_req     (er),
        .excp_flush_add_op1 (eo1),
        .excp_flush_add_op2 (eo2),
        .brch_flush_req     (br),
        .brch_flush_add_op1 (bo1),
        .brch_flush_add_op2 (bo2),
        .excp_flush_ack     (ea_s),
        .brch_flush_ack     (ba_s),
        .pipe_flush_req     (pr_s),
        .pipe_flush_add_op1 (po1_s),
        .pipe_flush_add_op2 (po2_s),
        .pipe_flush_src     (ps_s),
        .pipe_flush_ack     (pa),
        .flush_busy         (busy_s),
        .excp_flush_cnt     (ec_s),
        .brch_flush_cnt     (bc_s)
    );

    typedef struct {
        logic        rst;
        logic        er;
        logic [31:0] eo1;
        logic [31:0] eo2;
        logic        br;
        logic [31:0] bo1;
        logic [31:0] bo2;
        logic        pa;
        logic        ea;
        logic        ba;
        logic        pr;
        logic [31:0] po1;
        logic [31:0] po2;
        logic        ps;
        logic        ck;
        logic [15:0] ec;
        logic [15:0] bc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic i_rst, input logic i_er,
        input logic [31:0] i_eo1, input logic [31:0] i_eo2,
        input logic i_br,
        input logic [31:0] i_bo1, input logic [31:0] i_bo2,
        input logic i_pa,
        input logic x_ea, input logic x_ba, input logic x_pr,
        input logic [31:0] x_po1, input logic [31:0] x_po2,
        input logic x_ps, input logic x_ck,
        input logic [15:0] x_ec, input logic [15:0] x_bc
    );
        vec_t v;
        v.rst = i_rst; v.er = i_er; v.eo1 = i_eo1; v.eo2 = i_eo2;
        v.br = i_br; v.bo1 = i_bo1; v.bo2 = i_bo2; v.pa = i_pa;
        v.ea = x_ea; v.ba = x_ba; v.pr = x_pr;
        v.po1 = x_po1; v.po2 = x_po2; v.ps = x_ps; v.ck = x_ck;
        v.ec = x_ec; v.bc = x_bc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    endtask

    localparam logic [31:0] DB = 32'hDEAD_BEEF;

    initial begin
        logic [1:0] sat_exp [5];
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        // rst er eo1 eo2 br bo1 bo2 pa | ea ba pr po1 po2 ps ck ec bc
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        add(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,1,0,0);
        add(0,0,0,0,1,32'h8000_0100,32'h10,0, 0,0,0,0,0,0,1,0,0);
        add(0,0,0,0,1,32'h8000_0100,32'h10,0,
            0,0,1,32'h8000_0100,32'h10,0,1,0,0);
        add(0,0,0,0,1,32'h8000_0100,32'h10,1,
            0,1,1,32'h8000_0100,32'h10,0,1,0,0);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
        add(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,1);
        add(0,1,32'h200,0,1,32'h8000_0200,4,0, 0,0,0,0,0,0,1,0,0);
        add(0,1,32'h200,0,1,32'h8000_0200,4,1,
            1,0,1,32'h200,0,1,1,0,0);
        add(0,0,0,0,1,32'h8000_0200,4,0, 0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,1,32'h8000_0200,4,1,
            0,1,1,32'h8000_0200,4,0,1,1,0);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,1);
        add(0,0,0,0,1,32'h8000_0300,8,0, 0,0,0,0,0,0,0,1,1);
        add(0,1,32'h300,4,1,DB,DB,0, 0,0,1,32'h8000_0300,8,0,1,1,1);
        add(0,1,32'h300,4,1,DB,DB,0, 0,0,1,32'h8000_0300,8,0,1,1,1);
        add(0,1,32'h300,4,1,DB,DB,1, 0,1,1,32'h8000_0300,8,0,1,1,1);
        add(0,1,32'h300,4,0,0,0,0, 0,0,0,0,0,0,0,1,2);
        add(0,1,32'h300,4,0,0,0,1, 1,0,1,32'h300,4,1,1,1,2);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,2,2);
        add(0,0,0,0,1,32'h8000_0400,0,0, 0,0,0,0,0,0,0,2,2);
        add(1,0,0,0,1,32'h8000_0400,0,0,
            0,0,1,32'h8000_0400,0,0,1,2,2);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        add(0,1,32'h500,8,0,0,0,0, 0,0,0,0,0,0,1,0,0);
        add(0,0,0,0,0,0,0,0, 0,0,1,32'h500,8,1,1,0,0);
        add(0,0,0,0,0,0,0,1, 1,0,1,32'h500,8,1,1,0,0);
        add(0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,1,0);
        add(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1,0);

        rst = 1'b1; er = 0; br = 0; pa = 0;
        eo1 = '0; eo2 = '0; bo1 = '0; bo2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            rst = vecs[i].rst; er = vecs[i].er;
            eo1 = vecs[i].eo1; eo2 = vecs[i].eo2;
            br = vecs[i].br;
            bo1 = vecs[i].bo1; bo2 = vecs[i].bo2;
            pa = vecs[i].pa;
            #1;
            chk("excp_ack", i, ea, vecs[i].ea);
            chk("brch_ack", i, ba, vecs[i].ba);
            chk("pipe_req", i, pr, vecs[i].pr);
            chk("busy", i, busy, vecs[i].pr);
            chk("excp_cnt", i, ec, vecs[i].ec);
            chk("brch_cnt", i, bc, vecs[i].bc);
            if (vecs[i].ck) begin
                chk("op1", i, po1, vecs[i].po1);
                chk("op2", i, po2, vecs[i].po2);
                chk("src", i, ps, vecs[i].ps);
            end
            @(negedge clk);
        end

        // Saturation with a continuously held branch request:
        // every grant is separated by one IDLE bubble.
        rst = 1'b1; er = 0; br = 0; pa = 0;
        @(negedge clk);
        rst = 1'b0; br = 1'b1;
        bo1 = 32'h8000_0500; bo2 = 32'h2;
        for (int i = 0; i < 5; i++) begin
            pa = 1'b0;
            #1;
            chk("sat_idle_req", i, pr_s, 1'b0);
            if (i > 0) chk("sat_cnt", i, bc_s, sat_exp[i-1]);
            @(negedge clk);
            pa = 1'b1;
            #1;
            chk("sat_hold_req", i, pr_s, 1'b1);
            chk("sat_ack", i, ba_s, 1'b1);
            @(negedge clk);
        end
        pa = 1'b0; br = 1'b0;
        #1;
        chk("sat_cnt", 5, bc_s, sat_exp[4]);
        chk("wide_cnt", 5, bc, 16'd5);
        chk("sat_excp_cnt", 5, ec_s, 2'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
